// File: rtl/cmp_unit_serial_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | cmp_pkg                                                                |
// | Shared funct3 codes, FSM encoding and decode helpers for the serial    |
// | RISC-V branch-condition compare unit.                                  |
// | Revision: 1.0 - initial release                                        |
// +------------------------------------------------------------------------+
package cmp_pkg;

  // funct3 encodings of the branch compares (010/011 are not compares)
  localparam logic [2:0] CMP_EQ  = 3'b000;
  localparam logic [2:0] CMP_NE  = 3'b001;
  localparam logic [2:0] CMP_LT  = 3'b100;
  localparam logic [2:0] CMP_GE  = 3'b101;
  localparam logic [2:0] CMP_LTU = 3'b110;
  localparam logic [2:0] CMP_GEU = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } cmp_state_e;

  // LT/GE compare two's-complement values; everything else is unsigned
  function automatic logic is_signed_op(input logic [2:0] op);
    return (op == CMP_LT) || (op == CMP_GE);
  endfunction

  function automatic logic is_illegal_op(input logic [2:0] op);
    return op[2:1] == 2'b01;
  endfunction

  // Branch condition from the raw less-than / equal flags
  function automatic logic branch_taken(input logic [2:0] op, input logic lt, input logic eq);
    logic res;
    case (op)
      CMP_EQ:          res = eq;
      CMP_NE:          res = !eq;
      CMP_LT, CMP_LTU: res = lt;
      default:         res = !lt;
    endcase
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cmp_unit_serial_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | cmp_unit_serial_if                                                     |
// | Request/response handshake bundle of the serial compare unit.          |
// | Revision: 1.0 - initial release                                        |
// +------------------------------------------------------------------------+
interface cmp_unit_serial_if #(
  parameter int XLEN = 32
) ();

  logic            in_valid;
  logic            in_ready;
  logic [2:0]      in_op;
  logic [XLEN-1:0] in_a;
  logic [XLEN-1:0] in_b;
  logic            out_valid;
  logic            out_ready;
  logic            out_taken;
  logic            out_lt;
  logic            out_eq;
  logic            out_illegal;
  logic            busy;

  // Requester side: issues operands, consumes results
  modport master (
    output in_valid, in_op, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_taken, out_lt, out_eq, out_illegal, busy
  );

  // Compare unit side
  modport slave (
    input  in_valid, in_op, in_a, in_b, out_ready,
    output in_ready, out_valid, out_taken, out_lt, out_eq, out_illegal, busy
  );

endinterface
`default_nettype wire

// File: rtl/cmp_unit_serial_chunk.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | cmp_chunk                                                              |
// | Combinational unsigned compare of one CHUNK-bit slice.                 |
// | Revision: 1.0 - initial release                                        |
// +------------------------------------------------------------------------+
module cmp_chunk #(
  parameter int CHUNK = 8
) (
  input  wire  [CHUNK-1:0] a_chunk,
  input  wire  [CHUNK-1:0] b_chunk,
  output logic             lt,
  output logic             eq
);

  assign lt = (a_chunk < b_chunk);
  assign eq = (a_chunk == b_chunk);

endmodule
`default_nettype wire

// File: rtl/cmp_unit_serial.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | cmp_unit_serial                                                        |
// | Multi-cycle BEQ/BNE/BLT/BGE/BLTU/BGEU condition unit. Scans operands   |
// | CHUNK bits per cycle from the MSB down and stops at the first          |
// | differing slice. Signed ops are handled by flipping both MSBs.         |
// | Revision: 1.0 - initial release                                        |
// +------------------------------------------------------------------------+
module cmp_unit_serial
  import cmp_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CHUNK = 8
) (
  input  wire              clk,
  input  wire              rst_n,
  cmp_unit_serial_if.slave bus
);

  localparam int NCHUNK = XLEN / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] IDX_TOP   = IDXW'(NCHUNK - 1);
  localparam logic [XLEN-1:0] SIGN_MASK = XLEN'(1) << (XLEN - 1);

  generate
    if ((CHUNK < 1) || (CHUNK > XLEN) || ((XLEN % CHUNK) != 0)) begin : g_bad_params
      $error("cmp_unit_serial: XLEN must be a positive multiple of CHUNK");
    end
  endgenerate

  cmp_state_e      state_q, state_d;
  logic [XLEN-1:0] a_q, a_d;
  logic [XLEN-1:0] b_q, b_d;
  logic [2:0]      op_q, op_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic            valid_q, valid_d;
  logic            taken_q, taken_d;
  logic            lt_q, lt_d;
  logic            eq_q, eq_d;
  logic            illegal_q, illegal_d;

  logic [CHUNK-1:0] a_chunk_sel;
  logic [CHUNK-1:0] b_chunk_sel;
  logic             chunk_lt;
  logic             chunk_eq;

  // Select the slice addressed by idx for the single shared comparator
  always_comb begin
    a_chunk_sel = '0;
    b_chunk_sel = '0;
    for (int i = 0; i < NCHUNK; i++) begin
      if (idx_q == IDXW'(i)) begin
        a_chunk_sel = a_q[i*CHUNK +: CHUNK];
        b_chunk_sel = b_q[i*CHUNK +: CHUNK];
      end
    end
  end

  cmp_chunk #(
    .CHUNK (CHUNK)
  ) u_chunk (
    .a_chunk (a_chunk_sel),
    .b_chunk (b_chunk_sel),
    .lt      (chunk_lt),
    .eq      (chunk_eq)
  );

  // Next-state and result logic; result flags change only when entering DONE
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    idx_d     = idx_q;
    valid_d   = valid_q;
    taken_d   = taken_q;
    lt_d      = lt_q;
    eq_d      = eq_q;
    illegal_d = illegal_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          op_d = bus.in_op;
          if (is_illegal_op(bus.in_op)) begin
            state_d   = DONE;
            valid_d   = 1'b1;
            illegal_d = 1'b1;
            taken_d   = 1'b0;
            lt_d      = 1'b0;
            eq_d      = 1'b0;
          end else begin
            // MSB flip turns a signed order into an unsigned one
            a_d     = bus.in_a ^ (is_signed_op(bus.in_op) ? SIGN_MASK : '0);
            b_d     = bus.in_b ^ (is_signed_op(bus.in_op) ? SIGN_MASK : '0);
            idx_d   = IDX_TOP;
            state_d = SCAN;
          end
        end
      end
      SCAN: begin
        // A differing slice decides the order; all-equal down to slice 0 means a == b
        if (!chunk_eq || (idx_q == '0)) begin
          state_d   = DONE;
          valid_d   = 1'b1;
          illegal_d = 1'b0;
          lt_d      = chunk_lt;
          eq_d      = chunk_eq;
          taken_d   = branch_taken(op_q, chunk_lt, chunk_eq);
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
          valid_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset drops any operation in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= '0;
      idx_q     <= '0;
      valid_q   <= 1'b0;
      taken_q   <= 1'b0;
      lt_q      <= 1'b0;
      eq_q      <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      op_q      <= op_d;
      idx_q     <= idx_d;
      valid_q   <= valid_d;
      taken_q   <= taken_d;
      lt_q      <= lt_d;
      eq_q      <= eq_d;
      illegal_q <= illegal_d;
    end
  end

  assign bus.in_ready    = (state_q == IDLE);
  assign bus.busy        = (state_q != IDLE);
  assign bus.out_valid   = valid_q;
  assign bus.out_taken   = taken_q;
  assign bus.out_lt      = lt_q;
  assign bus.out_eq      = eq_q;
  assign bus.out_illegal = illegal_q;

endmodule
`default_nettype wire

// File: tb/tb_cmp_unit_serial.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_cmp_unit_serial                                                     |
// | Self-checking bench for three configurations of cmp_unit_serial:       |
// | 32/8, 64/16 and 32/32, against a plain-arithmetic reference model.     |
// | Revision: 1.0 - initial release                                        |
// +------------------------------------------------------------------------+
module tb_cmp_unit_serial;
  import cmp_pkg::*;

  // flags = {taken, lt, eq, illegal}
  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic [2:0]  op;
    logic [3:0]  flags;
    int          lat;
  } vec_t;

  int cfg_xlen  [3] = '{32, 64, 32};
  int cfg_chunk [3] = '{8, 16, 32};
  logic [2:0] legal_ops [6] = '{CMP_EQ, CMP_NE, CMP_LT, CMP_GE, CMP_LTU, CMP_GEU};

  logic        clk = 1'b0;
  logic        rst_n;
  logic        drv_valid;
  logic [63:0] drv_a;
  logic [63:0] drv_b;
  logic [2:0]  drv_op;
  logic        out_rdy;
  int          sel;
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk = ~clk;

  cmp_unit_serial_if #(.XLEN(32)) if0 ();
  cmp_unit_serial_if #(.XLEN(64)) if1 ();
  cmp_unit_serial_if #(.XLEN(32)) if2 ();

  assign if0.in_valid  = drv_valid && (sel == 0);
  assign if0.in_op     = drv_op;
  assign if0.in_a      = drv_a[31:0];
  assign if0.in_b      = drv_b[31:0];
  assign if0.out_ready = out_rdy;
  assign if1.in_valid  = drv_valid && (sel == 1);
  assign if1.in_op     = drv_op;
  assign if1.in_a      = drv_a;
  assign if1.in_b      = drv_b;
  assign if1.out_ready = out_rdy;
  assign if2.in_valid  = drv_valid && (sel == 2);
  assign if2.in_op     = drv_op;
  assign if2.in_a      = drv_a[31:0];
  assign if2.in_b      = drv_b[31:0];
  assign if2.out_ready = out_rdy;

  cmp_unit_serial #(.XLEN(32), .CHUNK(8))  u_dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  cmp_unit_serial #(.XLEN(64), .CHUNK(16)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  cmp_unit_serial #(.XLEN(32), .CHUNK(32)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));

  logic o_valid, o_ready, o_taken, o_lt, o_eq, o_ill, o_busy;

  always_comb begin
    {o_valid, o_ready, o_taken, o_lt, o_eq, o_ill, o_busy} = '0;
    case (sel)
      0: {o_valid, o_ready, o_taken, o_lt, o_eq, o_ill, o_busy} =
           {if0.out_valid, if0.in_ready, if0.out_taken, if0.out_lt, if0.out_eq, if0.out_illegal, if0.busy};
      1: {o_valid, o_ready, o_taken, o_lt, o_eq, o_ill, o_busy} =
           {if1.out_valid, if1.in_ready, if1.out_taken, if1.out_lt, if1.out_eq, if1.out_illegal, if1.busy};
      default: {o_valid, o_ready, o_taken, o_lt, o_eq, o_ill, o_busy} =
           {if2.out_valid, if2.in_ready, if2.out_taken, if2.out_lt, if2.out_eq, if2.out_illegal, if2.busy};
    endcase
  end

  function automatic logic [63:0] xmask(input int xlen);
    return (xlen >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << xlen) - 64'd1);
  endfunction

  // Reference: flags from integer compares, latency from the highest differing bit
  function automatic void ref_model(input logic [63:0] a_in, input logic [63:0] b_in, input logic [2:0] op,
                                    input int xlen, input int chunk, output logic [3:0] flags, output int lat);
    logic [63:0] a, b, d;
    longint      sa, sb;
    logic        lt, eq, tk;
    int          p;
    a  = a_in & xmask(xlen);
    b  = b_in & xmask(xlen);
    sa = longint'(a << (64 - xlen)) >>> (64 - xlen);
    sb = longint'(b << (64 - xlen)) >>> (64 - xlen);
    eq = (a == b);
    lt = (op == CMP_LT || op == CMP_GE) ? (sa < sb) : (a < b);
    case (op)
      CMP_EQ:          tk = eq;
      CMP_NE:          tk = !eq;
      CMP_LT, CMP_LTU: tk = lt;
      default:         tk = !lt;
    endcase
    d = a ^ b;
    p = -1;
    for (int i = 0; i < xlen; i++) if (d[i]) p = i;
    if (op == 3'b010 || op == 3'b011) begin
      flags = 4'b0001;
      lat   = 1;
    end else begin
      flags = {tk, lt, eq, 1'b0};
      lat   = (p < 0) ? (xlen / chunk + 1) : ((xlen - 1 - p) / chunk + 2);
    end
  endfunction

  function automatic logic [63:0] rnd64(input int xlen);
    return {$urandom, $urandom} & xmask(xlen);
  endfunction

  // Issue one request (called #1 after an edge with in_ready high); lat counts edges from accept to first edge seeing out_valid
  task automatic do_op(input logic [63:0] a, input logic [63:0] b, input logic [2:0] op,
                       output logic [3:0] flags, output int lat, output bit ok);
    int n;
    drv_a     = a;
    drv_b     = b;
    drv_op    = op;
    drv_valid = 1'b1;
    @(posedge clk); #1;
    drv_valid = 1'b0;
    drv_a     = {$urandom, $urandom};
    drv_b     = {$urandom, $urandom};
    drv_op    = 3'($urandom);
    n = 0;
    while (!o_valid && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    ok    = (o_valid === 1'b1);
    lat   = n + 1;
    flags = {o_taken, o_lt, o_eq, o_ill};
    if (out_rdy) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    drv_valid = 1'b0;
    out_rdy   = 1'b1;
    rst_n     = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    n_tests++;
    if ({o_valid, o_taken, o_lt, o_eq, o_ill, o_busy} !== 6'b0) begin
      n_fail++;
      $display("FAIL cfg%0d reset_outputs: got %b expected 000000", sel, {o_valid, o_taken, o_lt, o_eq, o_ill, o_busy});
    end
    n_tests++;
    if (o_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL cfg%0d reset_in_ready: got %b expected 1", sel, o_ready);
    end
    @(posedge clk); #1;
    n_tests++;
    if ({o_valid, o_ready, o_busy} !== 3'b010) begin
      n_fail++;
      $display("FAIL cfg%0d idle_after_reset {valid,ready,busy}: got %b expected 010", sel, {o_valid, o_ready, o_busy});
    end
  endtask

  task automatic test_directed();
    vec_t       tbl [9];
    logic [3:0] got, exp_f;
    int         lat, exp_l;
    bit         ok;
    tbl[0] = '{64'h1, 64'hFFFF_FFFF, CMP_LTU, 4'b1100, 2};
    tbl[1] = '{64'h1, 64'hFFFF_FFFF, CMP_LT,  4'b0000, 2};
    tbl[2] = '{64'h1, 64'hFFFF_FFFF, CMP_GE,  4'b1000, 2};
    tbl[3] = '{64'h5, 64'h5, CMP_EQ, 4'b1010, 5};
    tbl[4] = '{64'h5, 64'h5, CMP_NE, 4'b0010, 5};
    tbl[5] = '{64'h100, 64'h200, CMP_LTU, 4'b1100, 4};
    tbl[6] = '{64'h8000_0000, 64'h7FFF_FFFF, CMP_LT,  4'b1100, 2};
    tbl[7] = '{64'h8000_0000, 64'h7FFF_FFFF, CMP_LTU, 4'b0000, 2};
    tbl[8] = '{64'h0, 64'h0, 3'b010, 4'b0001, 1};
    for (int i = 0; i < 9; i++) begin
      if (sel == 0) begin
        exp_f = tbl[i].flags;
        exp_l = tbl[i].lat;
      end else if (sel == 2) begin
        exp_f = tbl[i].flags;
        exp_l = tbl[i].flags[0] ? 1 : 2;
      end else begin
        ref_model(tbl[i].a, tbl[i].b, tbl[i].op, cfg_xlen[sel], cfg_chunk[sel], exp_f, exp_l);
      end
      do_op(tbl[i].a, tbl[i].b, tbl[i].op, got, lat, ok);
      n_tests++;
      if (!ok || got !== exp_f) begin
        n_fail++;
        $display("FAIL cfg%0d directed[%0d] {taken,lt,eq,ill}: got %b (valid %0b) expected %b", sel, i, got, ok, exp_f);
      end
      n_tests++;
      if (lat != exp_l) begin
        n_fail++;
        $display("FAIL cfg%0d directed[%0d] latency: got %0d expected %0d", sel, i, lat, exp_l);
      end
    end
  endtask

  task automatic test_random();
    logic [63:0] a, b;
    logic [2:0]  op;
    logic [3:0]  got, exp_f;
    int          lat, exp_l, xl;
    bit          ok;
    xl = cfg_xlen[sel];
    for (int i = 0; i < 40; i++) begin
      a = rnd64(xl);
      case ($urandom_range(0, 3))
        0:       b = rnd64(xl);
        1:       b = a;
        2:       b = a ^ (64'd1 << $urandom_range(0, xl - 1));
        default: b = (a & ~64'hFFFF) | (rnd64(xl) & 64'hFFFF);
      endcase
      op = 3'($urandom);
      ref_model(a, b, op, xl, cfg_chunk[sel], exp_f, exp_l);
      do_op(a, b, op, got, lat, ok);
      n_tests++;
      if (!ok || got !== exp_f || lat != exp_l) begin
        n_fail++;
        $display("FAIL cfg%0d random[%0d] a=%h b=%h op=%b: got flags %b lat %0d valid %0b, expected flags %b lat %0d",
                 sel, i, a, b, op, got, lat, ok, exp_f, exp_l);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] a, b;
    logic [2:0]  op;
    logic [3:0]  got, exp_f;
    int          lat, exp_l;
    bit          ok;
    for (int i = 0; i < 6; i++) begin
      n_tests++;
      if ({o_valid, o_ready, o_busy} !== 3'b010) begin
        n_fail++;
        $display("FAIL cfg%0d b2b_ready[%0d] {valid,ready,busy}: got %b expected 010", sel, i, {o_valid, o_ready, o_busy});
      end
      a  = rnd64(cfg_xlen[sel]);
      b  = (i % 2 == 0) ? a : rnd64(cfg_xlen[sel]);
      op = legal_ops[$urandom_range(0, 5)];
      ref_model(a, b, op, cfg_xlen[sel], cfg_chunk[sel], exp_f, exp_l);
      do_op(a, b, op, got, lat, ok);
      n_tests++;
      if (!ok || got !== exp_f || lat != exp_l) begin
        n_fail++;
        $display("FAIL cfg%0d b2b[%0d]: got flags %b lat %0d valid %0b, expected flags %b lat %0d", sel, i, got, lat, ok, exp_f, exp_l);
      end
    end
  endtask

  task automatic test_stall();
    logic [63:0] a, b;
    logic [2:0]  op;
    logic [3:0]  got, exp_f;
    int          lat, exp_l;
    bit          ok;
    out_rdy = 1'b0;
    a  = rnd64(cfg_xlen[sel]);
    b  = rnd64(cfg_xlen[sel]);
    op = legal_ops[$urandom_range(0, 5)];
    ref_model(a, b, op, cfg_xlen[sel], cfg_chunk[sel], exp_f, exp_l);
    do_op(a, b, op, got, lat, ok);
    n_tests++;
    if (!ok || got !== exp_f) begin
      n_fail++;
      $display("FAIL cfg%0d stall_result: got flags %b valid %0b expected flags %b", sel, got, ok, exp_f);
    end
    for (int i = 0; i < 10; i++) begin
      drv_valid = 1'b1;
      drv_a     = {$urandom, $urandom};
      drv_b     = drv_a;
      drv_op    = CMP_EQ;
      @(posedge clk); #1;
      n_tests++;
      if ({o_valid, o_ready, o_busy, o_taken, o_lt, o_eq, o_ill} !== {3'b101, exp_f}) begin
        n_fail++;
        $display("FAIL cfg%0d stall_hold[%0d] {valid,ready,busy,flags}: got %b expected %b",
                 sel, i, {o_valid, o_ready, o_busy, o_taken, o_lt, o_eq, o_ill}, {3'b101, exp_f});
      end
    end
    out_rdy = 1'b1;
    @(posedge clk); #1;
    drv_valid = 1'b0;
    n_tests++;
    if ({o_valid, o_ready, o_busy} !== 3'b010) begin
      n_fail++;
      $display("FAIL cfg%0d stall_release {valid,ready,busy}: got %b expected 010", sel, {o_valid, o_ready, o_busy});
    end
    a  = rnd64(cfg_xlen[sel]);
    op = legal_ops[$urandom_range(0, 5)];
    ref_model(a, a, op, cfg_xlen[sel], cfg_chunk[sel], exp_f, exp_l);
    do_op(a, a, op, got, lat, ok);
    n_tests++;
    if (!ok || got !== exp_f || lat != exp_l) begin
      n_fail++;
      $display("FAIL cfg%0d after_stall: got flags %b lat %0d valid %0b, expected flags %b lat %0d", sel, got, lat, ok, exp_f, exp_l);
    end
  endtask

  task automatic test_reset_mid_scan();
    logic [63:0] a;
    logic [3:0]  got, exp_f;
    int          lat, exp_l;
    bit          ok;
    do_op(64'h5, 64'h5, CMP_EQ, got, lat, ok);
    a         = rnd64(cfg_xlen[sel]);
    drv_a     = a;
    drv_b     = a;
    drv_op    = CMP_EQ;
    drv_valid = 1'b1;
    @(posedge clk); #1;
    drv_valid = 1'b0;
    @(posedge clk); #1;
    n_tests++;
    if (o_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL cfg%0d mid_scan_busy: got %b expected 1", sel, o_busy);
    end
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({o_valid, o_ready, o_taken, o_lt, o_eq, o_ill, o_busy} !== 7'b0100000) begin
      n_fail++;
      $display("FAIL cfg%0d async_reset {valid,ready,taken,lt,eq,ill,busy}: got %b expected 0100000",
               sel, {o_valid, o_ready, o_taken, o_lt, o_eq, o_ill, o_busy});
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      n_tests++;
      if ({o_valid, o_busy} !== 2'b00) begin
        n_fail++;
        $display("FAIL cfg%0d post_reset_idle[%0d] {valid,busy}: got %b expected 00", sel, i, {o_valid, o_busy});
      end
    end
    a = rnd64(cfg_xlen[sel]);
    ref_model(a, ~a, CMP_GEU, cfg_xlen[sel], cfg_chunk[sel], exp_f, exp_l);
    do_op(a, ~a, CMP_GEU, got, lat, ok);
    n_tests++;
    if (!ok || got !== exp_f || lat != exp_l) begin
      n_fail++;
      $display("FAIL cfg%0d after_reset_op: got flags %b lat %0d valid %0b, expected flags %b lat %0d", sel, got, lat, ok, exp_f, exp_l);
    end
  endtask

  initial begin
    drv_valid = 1'b0;
    drv_a     = '0;
    drv_b     = '0;
    drv_op    = '0;
    out_rdy   = 1'b1;
    sel       = 0;
    rst_n     = 1'b0;
    for (int s = 0; s < 3; s++) begin
      sel = s;
      test_reset();
      test_directed();
      test_random();
      test_back_to_back();
      test_stall();
      test_reset_mid_scan();
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached with %0d tests run", n_tests);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
